// File: rtl/mult_div_unit.sv
// Iterative Hi/Lo multiply/divide unit: shift-add multiply, restoring divide.
// Start/done handshake with sign correction and divide-by-zero flag.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t state, state_nx;

  logic               is_div;
  logic               neg_a;
  logic               neg_b;
  logic               zero_q;
  logic               done_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  logic               sgn_in;
  logic               a_neg_in;
  logic               b_neg_in;
  logic               b_zero;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  assign sgn_in   = ~op[0];
  assign a_neg_in = sgn_in & a[WIDTH-1];
  assign b_neg_in = sgn_in & b[WIDTH-1];
  assign a_mag    = a_neg_in ? -a : a;
  assign b_mag    = b_neg_in ? -b : b;
  assign b_zero   = (b == '0);

  // Multiply: add multiplicand into the upper half, shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nx;

  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, shift left.
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   diff;
  logic               fits;
  logic [2*WIDTH-1:0] div_nx;

  assign trial  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff   = trial[WIDTH-1:0] - opnd;
  assign fits   = (trial >= {1'b0, opnd});
  assign div_nx = fits
    ? {diff, acc[WIDTH-2:0], 1'b1}
    : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign prod = (neg_a ^ neg_b) ? -acc : acc;
  assign quo  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0]
                                : acc[WIDTH-1:0];
  assign rem  = neg_a ? -acc[2*WIDTH-1:WIDTH]
                      : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = (op[1] && b_zero) ? SIGN : RUN;
      RUN:  if (cnt == '0) state_nx = SIGN;
      SIGN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == SIGN);
    done = done_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_div   <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt      <= '0;
      opnd     <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            is_div   <= op[1];
            neg_a    <= a_neg_in;
            neg_b    <= b_neg_in;
            zero_q   <= op[1] & b_zero;
            opnd     <= op[1] ? b_mag : a_mag;
            acc      <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
            cnt      <= CW'(WIDTH - 1);
            div_zero <= 1'b0;
          end
        end
        RUN: begin
          acc <= is_div ? div_nx : mul_nx;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        SIGN: begin
          done_q <= 1'b1;
          if (zero_q) begin
            div_zero <= 1'b1;
          end else if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            {hi, lo} <= prod;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised iterative multiply/divide unit producing the Hi/Lo result pair for MULT, MULTU, DIV and DIVU in the multicycle CPU datapath. The control FSM starts it with a single-cycle `start` pulse and then waits on `busy`/`done`. On completion it loads the Hi and Lo registers via the HiSelect/LoSelect muxes. It generalises the fixed 32-bit Hi/Lo path to any operand width, uses a start/done handshake, and flags divide-by-zero.

## Interface
- `WIDTH`, default 32: operand width; Hi and Lo are each `WIDTH` bits; must be ≥ 4.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a`  in  WIDTH  multiplicand / dividend (register A value).
- `b`  in  WIDTH  multiplier / divisor (register B value).
- `busy`  out  1  high from the edge after `start` is accepted until the result edge.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid from this cycle on.
- `hi`  out  WIDTH  product high half / remainder.
- `lo`  out  WIDTH  product low half / quotient.
- `div_zero`  out  1  set with `done` when a DIV/DIVU has `b`=0; held until the next accepted start.

## Operation
- **States:** IDLE, RUN, SIGN.
- **IDLE:** on `start`=1, capture `op`, |a| and |b| (absolute value for signed ops, raw value for unsigned ops) and the result signs, set counter=WIDTH−1 and go to RUN. Exception: DIV/DIVU with `b`=0 goes straight to SIGN with the zero flag set.
- **RUN:** one iteration per cycle.
  - Multiply: shift-add, 2·WIDTH-bit accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - When counter=0 the iteration is the last one: go to SIGN. Otherwise decrement the counter.
- **SIGN:** apply sign correction and load `hi`/`lo`, pulse `done`, go to IDLE.
  - MULT: {hi,lo} = signed 2·WIDTH product.
  - MULTU: {hi,lo} = unsigned product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - Divide-by-zero: `hi`/`lo` unchanged, `div_zero`=1.
- **Overflow:** DIV of most-negative by −1 gives lo = most-negative, hi=0, no flag.
- **Arithmetic:** all wrap modulo 2^WIDTH per half. A magnitude of 2^(WIDTH−1) is handled as an unsigned WIDTH-bit value.
- **`start` while busy:** ignored (no queueing).
- **Operand stability:** `a`, `b` and `op` changes after capture have no effect.
- **Reset values** (`reset`=0, asynchronous): state IDLE, `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, all internal registers 0.
  - Reset mid-RUN aborts the operation with no `done`.
  - Release is synchronous to the next edge.

## Timing
- **Start edge E0:** the edge where `start`=1 is sampled in IDLE. `busy`=1 after E0.
- **Normal op:** RUN iterations on E1..E_WIDTH. SIGN on E_WIDTH+1: `hi`/`lo` update, `done`=1 for exactly one cycle, `busy`=0.
  - Latency: WIDTH+1 cycles (33 for WIDTH=32).
- **Divide-by-zero:** SIGN on E1. `done` and `div_zero` are asserted after E1, `busy` for one cycle.
- **Back-to-back:** `start` during the `done` cycle is accepted (state is already IDLE), giving zero bubble.
- **Register timing:** `hi`/`lo` change only on a SIGN edge or on reset. `div_zero` clears on the next accepted start edge.
- **Output decode:** `busy` and `done` are decoded from registered state only, with no combinational path from `start`.

## Test plan
- **MULT** a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; `done` 33 cycles after E0; `busy` high 33 cycles.
- **MULTU** a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
  - Same operands with MULT → hi=0, lo=1.
- **DIV** a=−7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7, b=2 → lo=3, hi=1.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- **DIV by zero:** first load hi=1, lo=3, then issue DIV a=5, b=0 → `done` and `div_zero` one cycle after E0; hi=1, lo=3 unchanged.
  - Next MULTU 2×3 start clears `div_zero`; result lo=6.
- **Handshake:**
  - Second `start` pulse at cycle 5 of a RUN → ignored, result unchanged.
  - `start` held during the `done` cycle → new op accepted, `done` again WIDTH+1 cycles later.
  - `reset`=0 at cycle 10 of RUN → `busy`, `done`, `hi`, `lo` all 0 immediately; no `done` after release.
- **WIDTH=8:** MULT 0x80×0x80 → hi=0x40, lo=0x00 in 9 cycles; DIVU 200/7 → lo=28, hi=4.
